// File: rtl/sort_output_checker.sv
// sort_output_checker: checks that a stream of elements from a sort stage is
// non-decreasing, counts the beats against a requested element count, records
// the first/last element and flags a stalled upstream with a watchdog.
// Optional feature: define SORT_CHK_CHECKSUM_EN to enable a 16-bit running sum
// of accepted elements; otherwise the checksum port is tied to zero.
module sort_output_checker #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned TIMEOUT   = 10000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [8:0]           n,
    input  logic                 in_valid,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 order_err,
    output logic                 timeout_err,
    output logic [8:0]           rx_count,
    output logic [DATAWIDTH-1:0] min_val,
    output logic [DATAWIDTH-1:0] max_val,
    output logic [15:0]          checksum
);

    localparam int unsigned CNT_W = 9;
    localparam int unsigned WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     n_lat;
    logic [WD_W-1:0]      wdog;
    logic [DATAWIDTH-1:0] prev;
    logic                 start_go;
    logic                 accept;
    logic                 wd_expire;

    // State register; status outputs are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == S_RUN);
            busy     <= (state_next != S_IDLE);
            done     <= (state_next == S_DONE);
        end
    end

    // Next-state logic: session start, final beat, watchdog expiry.
    always_comb begin
        state_next = state;
        start_go   = 1'b0;
        accept     = 1'b0;
        wd_expire  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_go   = 1'b1;
                    state_next = (n == CNT_W'(0)) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                accept = in_valid & in_ready;
                if (accept) begin
                    // A beat always beats the watchdog, final or not.
                    if (CNT_W'(rx_count + CNT_W'(1)) == n_lat) begin
                        state_next = S_DONE;
                    end
                end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                    wd_expire  = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Session datapath: count, first/last element, ordering check, watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_lat       <= '0;
            rx_count    <= '0;
            min_val     <= '0;
            max_val     <= '0;
            prev        <= '0;
            order_err   <= 1'b0;
            timeout_err <= 1'b0;
            wdog        <= '0;
        end else begin
            if (start_go) begin
                n_lat       <= n;
                rx_count    <= '0;
                min_val     <= '0;
                max_val     <= '0;
                prev        <= '0;
                order_err   <= 1'b0;
                timeout_err <= 1'b0;
                wdog        <= '0;
            end
            if (accept) begin
                rx_count <= CNT_W'(rx_count + CNT_W'(1));
                if (rx_count == CNT_W'(0)) begin
                    min_val <= in_data;
                end else if (in_data < prev) begin
                    order_err <= 1'b1;
                end
                max_val <= in_data;
                prev    <= in_data;
                wdog    <= '0;
            end else if (state == S_RUN) begin
                wdog <= WD_W'(wdog + WD_W'(1));
            end
            if (wd_expire) begin
                timeout_err <= 1'b1;
            end
        end
    end

`ifdef SORT_CHK_CHECKSUM_EN
    // Running modulo-2^16 sum of accepted elements, cleared on start.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (start_go) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= 16'(checksum + 16'(in_data));
        end
    end
`else
    // Checksum feature disabled: port kept, driven constant zero.
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_sort_output_checker.sv
// Directed self-checking bench for sort_output_checker (TIMEOUT overridden to 16).
module tb_sort_output_checker;

    localparam int unsigned DW = 8;
`ifdef SORT_CHK_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [8:0]    n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic          order_err;
    logic          timeout_err;
    logic [8:0]    rx_count;
    logic [DW-1:0] min_val;
    logic [DW-1:0] max_val;
    logic [15:0]   checksum;

    int n_cmp = 0;
    int n_err = 0;

    sort_output_checker #(.DATAWIDTH(DW), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .n           (n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .busy        (busy),
        .done        (done),
        .order_err   (order_err),
        .timeout_err (timeout_err),
        .rx_count    (rx_count),
        .min_val     (min_val),
        .max_val     (max_val),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [8:0] nv);
        start = 1'b1;
        n     = nv;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},     32'(busy),        32'd0);
        check({tag, ".in_ready"}, 32'(in_ready),    32'd0);
        check({tag, ".done"},     32'(done),        32'd0);
        check({tag, ".order"},    32'(order_err),   32'd0);
        check({tag, ".timeout"},  32'(timeout_err), 32'd0);
        check({tag, ".rx"},       32'(rx_count),    32'd0);
        check({tag, ".min"},      32'(min_val),     32'd0);
        check({tag, ".max"},      32'(max_val),     32'd0);
        check({tag, ".csum"},     32'(checksum),    32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; n = '0; in_valid = 1'b0; in_data = '0;
        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Ordered stream 3,5,5,9 with n=4
        do_start(9'd4);
        check("t1.in_ready", 32'(in_ready), 32'd1);
        check("t1.busy",     32'(busy),     32'd1);
        beat(8'd3); beat(8'd5); beat(8'd5);
        check("t1.no_early_done", 32'(done), 32'd0);
        beat(8'd9);
        check("t1.done",  32'(done),      32'd1);
        check("t1.rx",    32'(rx_count),  32'd4);
        check("t1.min",   32'(min_val),   32'd3);
        check("t1.max",   32'(max_val),   32'd9);
        check("t1.order", 32'(order_err), 32'd0);
        check("t1.csum",  32'(checksum),  CK_EN ? 32'd22 : 32'd0);
        tick();
        check("t1.done_pulse", 32'(done), 32'd0);
        check("t1.idle_busy",  32'(busy), 32'd0);
        check("t1.hold_rx",    32'(rx_count), 32'd4);

        // Out-of-order stream 7,2,8
        do_start(9'd3);
        beat(8'd7); beat(8'd2); beat(8'd8);
        check("t2.done",  32'(done),      32'd1);
        check("t2.order", 32'(order_err), 32'd1);
        check("t2.rx",    32'(rx_count),  32'd3);
        check("t2.min",   32'(min_val),   32'd7);
        check("t2.max",   32'(max_val),   32'd8);
        check("t2.csum",  32'(checksum),  CK_EN ? 32'd17 : 32'd0);
        tick();
        check("t2.hold_order", 32'(order_err), 32'd1);

        // Empty session n=0
        do_start(9'd0);
        check("t3.done",     32'(done),      32'd1);
        check("t3.busy",     32'(busy),      32'd1);
        check("t3.in_ready", 32'(in_ready),  32'd0);
        check("t3.rx",       32'(rx_count),  32'd0);
        check("t3.order",    32'(order_err), 32'd0);
        check("t3.min",      32'(min_val),   32'd0);
        check("t3.max",      32'(max_val),   32'd0);
        check("t3.csum",     32'(checksum),  32'd0);
        tick();
        check("t3.done_pulse", 32'(done), 32'd0);

        // Watchdog: 2 of 5 beats then silence for TIMEOUT=16 cycles
        do_start(9'd5);
        beat(8'd10); beat(8'd20);
        repeat (15) tick();
        check("t4.no_done_15", 32'(done),        32'd0);
        check("t4.to_15",      32'(timeout_err), 32'd0);
        tick();
        check("t4.done",    32'(done),        32'd1);
        check("t4.timeout", 32'(timeout_err), 32'd1);
        check("t4.rx",      32'(rx_count),    32'd2);
        tick();

        // Reset mid-session after 2 of 8 beats
        do_start(9'd8);
        beat(8'd1); beat(8'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("t5.rst");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5.no_done", 32'(done), 32'd0);
        end
        do_start(9'd2);
        beat(8'd4); beat(8'd6);
        check("t5.done", 32'(done),     32'd1);
        check("t5.rx",   32'(rx_count), 32'd2);
        check("t5.min",  32'(min_val),  32'd4);
        check("t5.max",  32'(max_val),  32'd6);
        check("t5.csum", 32'(checksum), CK_EN ? 32'd10 : 32'd0);
        tick();

        // in_valid in IDLE is ignored; second start during RUN is ignored
        for (int i = 0; i < 4; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 8'd200;
            tick();
        end
        in_valid = 1'b0;
        check("t6.idle_rx",  32'(rx_count), 32'd2);
        check("t6.idle_max", 32'(max_val),  32'd6);
        do_start(9'd3);
        beat(8'd11);
        do_start(9'd1);
        check("t6.busy",    32'(busy),     32'd1);
        check("t6.no_done", 32'(done),     32'd0);
        check("t6.rx1",     32'(rx_count), 32'd1);
        beat(8'd12);
        check("t6.no_done2", 32'(done), 32'd0);
        beat(8'd13);
        check("t6.done", 32'(done),     32'd1);
        check("t6.rx",   32'(rx_count), 32'd3);
        check("t6.min",  32'(min_val),  32'd11);
        check("t6.max",  32'(max_val),  32'd13);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sort_output_checker.md
SORT_OUTPUT_CHECKER -- requirements
Module: sort_output_checker

Interface
REQ-001 Parameter DATAWIDTH, default 8, bit width of each sorted element.
REQ-002 Parameter TIMEOUT, default 10000, maximum idle cycles allowed between accepted beats while running.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle pulse that latches n and begins a check session.
REQ-006 n  input  9  expected element count (0..511).
REQ-007 in_valid  input  1  upstream sorter presents in_data this cycle.
REQ-008 in_data  input  DATAWIDTH  sorted element from the sort stage.
REQ-009 in_ready  output  1  checker accepts a beat this cycle.
REQ-010 busy  output  1  session in progress.
REQ-011 done  output  1  one-cycle pulse at session end.
REQ-012 order_err  output  1  sticky flag: a strictly decreasing adjacent pair was seen.
REQ-013 timeout_err  output  1  sticky flag: the session ended by watchdog.
REQ-014 rx_count  output  9  beats accepted in the current or last session.
REQ-015 min_val, max_val  output  DATAWIDTH each  first and last accepted element.
REQ-016 checksum  output  16  modular sum of accepted elements (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE; DONE lasts exactly one cycle, then returns to IDLE.
REQ-018 IDLE with start=1 and n>0: latch n, clear rx_count, errors, min/max and checksum, then go to RUN next cycle.
REQ-019 IDLE with start=1 and n=0: go to DONE next cycle; all results stay 0 and no error is raised.
REQ-020 in_ready SHALL equal 1 only in RUN; a beat is accepted when in_valid and in_ready are both 1.
REQ-021 In IDLE or DONE, in_valid is ignored with no side effects.
REQ-022 On each accepted beat: rx_count increments by 1.
REQ-023 The first accepted beat of a session loads min_val.
REQ-024 Every accepted beat loads max_val.
REQ-025 Previous-element register is updated on every accepted beat.
REQ-026 For beats after the first, order_err is set if in_data < previous element (unsigned); equal values are legal.
REQ-027 The accepted beat that makes rx_count equal the latched n SHALL move the FSM to DONE on the next cycle.
REQ-028 done=1 is asserted for the single DONE cycle.
REQ-029 The watchdog counter resets on every accepted beat and on entry to RUN.
REQ-030 If the watchdog reaches TIMEOUT cycles with no accepted beat in RUN, set timeout_err and go to DONE.
REQ-031 If a final beat and watchdog expiry coincide, the beat wins: it is counted and timeout_err stays 0.
REQ-032 start while in RUN or DONE SHALL be ignored.
REQ-033 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-034 Result outputs and sticky errors hold their values after DONE until the next accepted start or reset.
REQ-035 Latency: done rises exactly 1 cycle after the n-th accepted beat.

Reset
REQ-036 When rst=1 at a rising edge, the FSM goes to IDLE regardless of current state, including mid-session.
REQ-037 Reset SHALL force in_ready, busy, done, order_err, timeout_err, rx_count, min_val, max_val, checksum, the watchdog and the latched n to 0.
REQ-038 A session interrupted by reset SHALL NOT produce a done pulse.

Configuration
REQ-039 Macro SORT_CHK_CHECKSUM_EN defined: checksum = (sum of accepted in_data, zero-extended) mod 2^16, cleared on start.
REQ-040 Macro SORT_CHK_CHECKSUM_EN undefined: the checksum port remains present and is tied to constant 0, with no adder logic.

Verification
REQ-041 Reset, start, n=4, beats 3,5,5,9 -> done one cycle after the 9; rx_count=4, min=3, max=9, order_err=0, checksum=22 (macro on).
REQ-042 start, n=3, beats 7,2,8 -> order_err=1 and done asserts; rx_count=3, min=7, max=8.
REQ-043 start, n=0 -> done one cycle later; all results 0, no errors.
REQ-044 start, n=5, 2 beats, then idle with TIMEOUT=16 -> timeout_err=1, done after 16 idle cycles, rx_count=2.
REQ-045 rst asserted mid-session after 2 of 8 beats -> next cycle all outputs 0, FSM IDLE, no done; a new start works normally.
REQ-046 in_valid toggling in IDLE, plus a second start during RUN -> no beats counted in IDLE, the second start is ignored, and the original n is used.
